iter_seq_ctrl: RTL and testbench



---
 rtl/iter_seq_ctrl_if.sv | 41 ++++
 rtl/iter_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_iter_seq_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/iter_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : iter_seq_ctrl_if
// Description : Control/status bundle between the top-level sequencer and the
//               iteration controller.
//               master : sequencer side (drives start/len/stall/abort/ack)
//               slave  : controller side (drives en/inc_*/idx/last/busy/
//                        ready/done_pulse)
// Revision    : 1.0 - initial release
// ============================================================================
interface iter_seq_ctrl_if #(
    parameter int CNT_W = 4
);
    // Sequencer -> controller
    logic             start;       // run request, level-sensitive
    logic [CNT_W-1:0] len;         // iteration count, 0 means 2^CNT_W
    logic             stall;       // hold the current iteration
    logic             abort;       // cancel the run
    logic             ack;         // clear sticky DONE

    // Controller -> sequencer / datapath
    logic             en;          // datapath enable for this iteration
    logic             inc_vector;  // advance vector pointer
    logic             inc_counter; // advance datapath counter
    logic [CNT_W-1:0] idx;         // current iteration index
    logic             last;        // current iteration is the final one
    logic             busy;        // armed or running
    logic             ready;       // run complete
    logic             done_pulse;  // first cycle of completion

    modport master (
        output start, len, stall, abort, ack,
        input  en, inc_vector, inc_counter, idx, last, busy, ready, done_pulse
    );

    modport slave (
        input  start, len, stall, abort, ack,
        output en, inc_vector, inc_counter, idx, last, busy, ready, done_pulse
    );
endinterface
`default_nettype wire

// File: rtl/iter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : iter_seq_ctrl
// Description : Iteration controller for vector-processing datapaths. A run
//               is requested with start, its length latched on acceptance,
//               and en is issued once per iteration while not stalled.
//               Optional start-release wait and sticky/pulsed completion.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - iter_seq_ctrl_if.slave (handshake, control, status)
// Revision    : 1.0 - initial release
// ============================================================================
module iter_seq_ctrl #(
    parameter int CNT_W        = 4,
    parameter int WAIT_RELEASE = 1,
    parameter int STICKY_DONE  = 1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    iter_seq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_ZERO = '0;
    // An accepted start either waits for start to drop or runs right away.
    localparam state_t c_START_NEXT = (WAIT_RELEASE != 0) ? S_ARM : S_RUN;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             done_pulse_q, done_pulse_d;

    logic             w_run;
    logic             w_en;
    logic             w_last;
    logic [CNT_W-1:0] w_len_m1;

    // len_q = 0 wraps to all ones, giving 2^CNT_W iterations.
    assign w_len_m1 = len_q - c_ONE;
    assign w_run    = (state_q == S_RUN);
    assign w_en     = w_run && !bus.stall && !bus.abort;
    assign w_last   = w_run && (idx_q == w_len_m1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= c_ZERO;
            len_q        <= c_ZERO;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        len_d        = len_q;
        done_pulse_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    len_d   = bus.len;
                    idx_d   = c_ZERO;
                    state_d = c_START_NEXT;
                end
            end
            S_ARM: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    idx_d   = c_ZERO;
                end else if (!bus.start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Abort wins over both step and stall; stall simply holds.
                if (bus.abort) begin
                    state_d = S_IDLE;
                    idx_d   = c_ZERO;
                end else if (w_en) begin
                    if (w_last) begin
                        state_d      = S_DONE;
                        done_pulse_d = 1'b1;
                    end else begin
                        idx_d = idx_q + c_ONE;
                    end
                end
            end
            S_DONE: begin
                if ((STICKY_DONE == 0) || bus.ack || bus.abort) begin
                    state_d = S_IDLE;
                    idx_d   = c_ZERO;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = c_ZERO;
            end
        endcase
    end

    assign bus.en          = w_en;
    assign bus.inc_vector  = w_en;
    assign bus.inc_counter = w_en;
    assign bus.idx         = idx_q;
    assign bus.last        = w_last;
    assign bus.busy        = (state_q == S_ARM) || w_run;
    assign bus.ready       = (state_q == S_DONE);
    assign bus.done_pulse  = done_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_iter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_iter_seq_ctrl
// Description : Self-checking bench. Two controllers share one stimulus
//               stream: instance 0 waits for start release with sticky
//               completion, instance 1 starts immediately with pulsed
//               completion. A run-level model predicts every output each
//               cycle; directed runs pin the model with literal totals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_seq_ctrl;

    localparam int W = 4;
    localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2, M_DONE = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         s_start, s_stall, s_abort, s_ack;
    logic [W-1:0] s_len;

    iter_seq_ctrl_if #(.CNT_W(W)) bus0 ();
    iter_seq_ctrl_if #(.CNT_W(W)) bus1 ();

    assign bus0.start = s_start;  assign bus1.start = s_start;
    assign bus0.len   = s_len;    assign bus1.len   = s_len;
    assign bus0.stall = s_stall;  assign bus1.stall = s_stall;
    assign bus0.abort = s_abort;  assign bus1.abort = s_abort;
    assign bus0.ack   = s_ack;    assign bus1.ack   = s_ack;

    iter_seq_ctrl #(.CNT_W(W), .WAIT_RELEASE(1), .STICKY_DONE(1)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0));
    iter_seq_ctrl #(.CNT_W(W), .WAIT_RELEASE(0), .STICKY_DONE(0)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1));

    int checks = 0;
    int errors = 0;

    // Run-level model: phase, index within run, run length (1..16).
    int m_st [2];
    int m_idx[2];
    int m_cnt[2];
    bit m_dp [2];
    int wr   [2] = '{1, 0};
    int sd   [2] = '{1, 0};
    int en_cnt[2];
    int dp_cnt[2];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = M_IDLE; m_idx[k] = 0; m_cnt[k] = 16; m_dp[k] = 0;
        end
    endtask

    task automatic clr_counts();
        for (int k = 0; k < 2; k++) begin
            en_cnt[k] = 0; dp_cnt[k] = 0;
        end
    endtask

    task automatic check_inst(input int k, input logic en, input logic iv,
                              input logic ic, input logic [W-1:0] idx,
                              input logic last, input logic busy,
                              input logic ready, input logic dp);
        bit run, e_en, e_last;
        run    = (m_st[k] == M_RUN);
        e_en   = run && !s_stall && !s_abort;
        e_last = run && (m_idx[k] + 1 == m_cnt[k]);
        chk($sformatf("i%0d.en", k),          int'(en),    int'(e_en));
        chk($sformatf("i%0d.inc_vector", k),  int'(iv),    int'(e_en));
        chk($sformatf("i%0d.inc_counter", k), int'(ic),    int'(e_en));
        chk($sformatf("i%0d.idx", k),         int'(idx),   m_idx[k]);
        chk($sformatf("i%0d.last", k),        int'(last),  int'(e_last));
        chk($sformatf("i%0d.busy", k),        int'(busy),
            int'(m_st[k] == M_ARM || run));
        chk($sformatf("i%0d.ready", k),       int'(ready), int'(m_st[k] == M_DONE));
        chk($sformatf("i%0d.done_pulse", k),  int'(dp),    int'(m_dp[k]));
        chk($sformatf("i%0d.ready_and_busy", k), int'(ready && busy), 0);
        if (en) en_cnt[k]++;
        if (dp) dp_cnt[k]++;
    endtask

    task automatic model_step(input int k);
        bit step, fin;
        step = (m_st[k] == M_RUN) && !s_stall && !s_abort;
        fin  = step && (m_idx[k] + 1 == m_cnt[k]);
        m_dp[k] = fin;
        case (m_st[k])
            M_IDLE: if (s_start && !s_abort) begin
                m_cnt[k] = (s_len == 0) ? 16 : int'(s_len);
                m_idx[k] = 0;
                m_st[k]  = wr[k] ? M_ARM : M_RUN;
            end
            M_ARM: begin
                if (s_abort) m_st[k] = M_IDLE;
                else if (!s_start) m_st[k] = M_RUN;
            end
            M_RUN: begin
                if (s_abort) begin
                    m_st[k] = M_IDLE; m_idx[k] = 0;
                end else if (fin) begin
                    m_st[k] = M_DONE;
                end else if (step) begin
                    m_idx[k]++;
                end
            end
            default: if (!sd[k] || s_ack || s_abort) begin
                m_st[k] = M_IDLE; m_idx[k] = 0;
            end
        endcase
    endtask

    // One clock: drive, check at the falling edge, advance model at the rising edge.
    task automatic cyc(input bit st, input int ln, input bit stl,
                       input bit ab, input bit ak);
        s_start = st; s_len = ln[W-1:0]; s_stall = stl; s_abort = ab; s_ack = ak;
        @(negedge clk);
        check_inst(0, bus0.en, bus0.inc_vector, bus0.inc_counter, bus0.idx,
                   bus0.last, bus0.busy, bus0.ready, bus0.done_pulse);
        check_inst(1, bus1.en, bus1.inc_vector, bus1.inc_counter, bus1.idx,
                   bus1.last, bus1.busy, bus1.ready, bus1.done_pulse);
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    // Abort returns both instances to idle from any phase.
    task automatic settle();
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        clr_counts();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        bit r_start;
        rst = 1'b1;
        s_start = 0; s_len = '0; s_stall = 0; s_abort = 0; s_ack = 0;
        model_reset();
        clr_counts();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.idx",   int'(bus0.idx),   0);
        chk("reset.busy",  int'(bus0.busy),  0);
        chk("reset.ready", int'(bus0.ready), 0);
        chk("reset.dp",    int'(bus0.done_pulse), 0);
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0);

        // len=5, start held 3 cycles
        clr_counts();
        repeat (3) cyc(1, 5, 0, 0, 0);
        repeat (8) cyc(0, 5, 0, 0, 0);
        chk("len5.en_count", en_cnt[0], 5);
        chk("len5.dp_count", dp_cnt[0], 1);
        chk("len5.ready_held", int'(bus0.ready), 1);
        chk("len5.final_idx", int'(bus0.idx), 4);
        chk("len5.i1_en_count", en_cnt[1], 5);
        cyc(0, 5, 0, 0, 1);
        chk("len5.idx_after_ack", int'(bus0.idx), 0);
        chk("len5.busy_after_ack", int'(bus0.busy), 0);

        // len=0 means 16 iterations
        settle();
        cyc(1, 0, 0, 0, 0);
        repeat (20) cyc(0, 0, 0, 0, 0);
        chk("len0.en_count", en_cnt[0], 16);
        chk("len0.final_idx", int'(bus0.idx), 15);
        chk("len0.ready", int'(bus0.ready), 1);
        chk("len0.i1_en_count", en_cnt[1], 16);

        // len=6 with a 3-cycle stall at idx=2
        settle();
        cyc(1, 6, 0, 0, 0);
        guard = 0;
        do begin
            cyc(0, 6, 0, 0, 0);
            guard++;
        end while (!(m_st[0] == M_RUN && m_idx[0] == 2) && guard < 10);
        chk("stall.reach_idx2_timeout", int'(guard < 10), 1);
        repeat (3) cyc(0, 6, 1, 0, 0);
        chk("stall.idx_held", int'(bus0.idx), 2);
        repeat (10) cyc(0, 6, 0, 0, 0);
        chk("stall.en_count", en_cnt[0], 6);

        // len=8 aborted at idx=3, then len=2 completes
        settle();
        cyc(1, 8, 0, 0, 0);
        guard = 0;
        do begin
            cyc(0, 8, 0, 0, 0);
            guard++;
        end while (!(m_st[0] == M_RUN && m_idx[0] == 3) && guard < 10);
        chk("abort.reach_idx3_timeout", int'(guard < 10), 1);
        cyc(0, 8, 0, 1, 0);
        chk("abort.busy", int'(bus0.busy), 0);
        chk("abort.idx", int'(bus0.idx), 0);
        repeat (3) cyc(0, 8, 0, 0, 0);
        chk("abort.en_count", en_cnt[0], 3);
        chk("abort.dp_count", dp_cnt[0], 0);
        clr_counts();
        cyc(1, 2, 0, 0, 0);
        repeat (6) cyc(0, 2, 0, 0, 0);
        chk("rerun.en_count", en_cnt[0], 2);
        chk("rerun.dp_count", dp_cnt[0], 1);
        cyc(0, 2, 0, 0, 1);

        // Pulsed completion, immediate start, start held through DONE
        settle();
        repeat (3) cyc(1, 1, 0, 0, 0);
        chk("pulsed.en_count", en_cnt[1], 1);
        chk("pulsed.dp_count", dp_cnt[1], 1);
        chk("pulsed.idle_busy", int'(bus1.busy), 0);
        chk("pulsed.idle_ready", int'(bus1.ready), 0);
        repeat (4) cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 1);

        // Asynchronous reset between clock edges in the middle of a run
        settle();
        cyc(1, 8, 0, 0, 0);
        repeat (4) cyc(0, 8, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst.i0_busy", int'(bus0.busy), 0);
        chk("arst.i0_idx",  int'(bus0.idx),  0);
        chk("arst.i0_en",   int'(bus0.en),   0);
        chk("arst.i1_busy", int'(bus1.busy), 0);
        chk("arst.i1_idx",  int'(bus1.idx),  0);
        chk("arst.i1_dp",   int'(bus1.done_pulse), 0);
        model_reset();
        #3 rst = 1'b0;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        clr_counts();
        repeat (4) cyc(0, 8, 0, 0, 0);
        chk("arst.idle_en_count", en_cnt[0] + en_cnt[1], 0);

        // Randomized traffic against the model
        r_start = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) r_start = !r_start;
            cyc(r_start, int'($urandom_range(0, 15)),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 24) == 0),
                ($urandom_range(0, 2) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
